// File: rtl/audio_i2s_transmitter_if.sv
// +--------------------------------------------------------------------------+
// | audio_i2s_transmitter_if : sample handshake and I2S pins of the serializer |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface audio_i2s_transmitter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  Enable;
  logic [DATA_WIDTH-1:0] SampleLeft;
  logic [DATA_WIDTH-1:0] SampleRight;
  logic                  SampleValid;
  logic                  SampleReady;
  logic                  BCLK;
  logic                  LRCLK;
  logic                  SDATA;
  logic                  Underrun;

  modport master (
    output Enable, SampleLeft, SampleRight, SampleValid,
    input  SampleReady, BCLK, LRCLK, SDATA, Underrun
  );

  modport slave (
    input  Enable, SampleLeft, SampleRight, SampleValid,
    output SampleReady, BCLK, LRCLK, SDATA, Underrun
  );
endinterface

`default_nettype wire

// File: rtl/audio_i2s_transmitter.sv
// +--------------------------------------------------------------------------+
// | audio_i2s_transmitter : double-buffered I2S serializer, BCLK by division |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module audio_i2s_transmitter #(
  parameter int DATA_WIDTH = 16,
  parameter int BCLK_DIV   = 10
) (
  input  logic                    MasterCLK,
  input  logic                    Reset,
  audio_i2s_transmitter_if.slave  bus
);
  localparam int C_FRAME_BITS = 2 * DATA_WIDTH;
  localparam int C_DIV_W      = $clog2(BCLK_DIV);
  localparam int C_SLOT_W     = $clog2(C_FRAME_BITS);
  localparam logic [C_DIV_W-1:0]  C_DIV_LAST  = C_DIV_W'(BCLK_DIV - 1);
  localparam logic [C_DIV_W-1:0]  C_DIV_HALF  = C_DIV_W'(BCLK_DIV / 2);
  localparam logic [C_DIV_W-1:0]  C_DIV_ONE   = C_DIV_W'(1);
  localparam logic [C_SLOT_W-1:0] C_SLOT_LAST = C_SLOT_W'(C_FRAME_BITS - 1);
  localparam logic [C_SLOT_W-1:0] C_SLOT_ONE  = C_SLOT_W'(1);
  localparam logic [C_SLOT_W-1:0] C_LR_FIRST  = C_SLOT_W'(DATA_WIDTH - 1);
  localparam logic [C_SLOT_W-1:0] C_LR_LAST   = C_SLOT_W'(C_FRAME_BITS - 2);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  r_state,      w_state_n;
  logic [C_DIV_W-1:0]      r_div,        w_div_n;
  logic [C_SLOT_W-1:0]     r_slot,       w_slot_n;
  logic [C_FRAME_BITS-1:0] r_shift,      w_shift_n;
  logic [C_FRAME_BITS-1:0] r_pend,       w_pend_n;
  logic                    r_pend_empty, w_pend_empty_n;
  logic                    r_bclk,       w_bclk_n;
  logic                    r_lrclk,      w_lrclk_n;
  logic                    r_sdata,      w_sdata_n;
  logic                    r_underrun,   w_underrun_n;
  logic                    w_take;
  logic                    w_wrap;
  logic                    w_frame_start;

  assign w_take = bus.SampleValid && r_pend_empty;

  always_comb begin
    w_state_n      = r_state;
    w_div_n        = r_div;
    w_slot_n       = r_slot;
    w_shift_n      = r_shift;
    w_pend_n       = r_pend;
    w_pend_empty_n = r_pend_empty;
    w_bclk_n       = 1'b0;
    w_lrclk_n      = r_lrclk;
    w_sdata_n      = r_sdata;
    w_underrun_n   = 1'b0;
    w_wrap         = 1'b0;
    w_frame_start  = 1'b0;

    if (!bus.Enable) begin
      w_state_n = ST_IDLE;
      w_div_n   = '0;
      w_slot_n  = '0;
      w_shift_n = '0;
      w_lrclk_n = 1'b0;
      w_sdata_n = 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        w_state_n     = ST_RUN;
        w_div_n       = '0;
        w_slot_n      = '0;
        w_frame_start = 1'b1;
      end else if (r_div == C_DIV_LAST) begin
        w_div_n = '0;
        w_wrap  = 1'b1;
        if (r_slot == C_SLOT_LAST) begin
          w_slot_n      = '0;
          w_frame_start = 1'b1;
        end else begin
          w_slot_n = r_slot + C_SLOT_ONE;
        end
      end else begin
        w_div_n = r_div + C_DIV_ONE;
      end

      w_bclk_n = (w_div_n >= C_DIV_HALF);

      // The word is rotated, so after the last slot its MSB holds the old frame's bit 0.
      if (w_wrap || w_frame_start) begin
        w_sdata_n = r_shift[C_FRAME_BITS-1];
        w_lrclk_n = (w_slot_n >= C_LR_FIRST) && (w_slot_n <= C_LR_LAST);
      end

      if (w_frame_start) begin
        w_underrun_n = r_pend_empty;
        w_shift_n    = r_pend_empty ? '0 : r_pend;
        if (!r_pend_empty) begin
          w_pend_empty_n = 1'b1;
        end
      end else if (w_wrap) begin
        w_shift_n = {r_shift[C_FRAME_BITS-2:0], r_shift[C_FRAME_BITS-1]};
      end
    end

    // A frame start with an empty buffer never sees the new pair: it waits a frame.
    if (w_take) begin
      w_pend_n       = {bus.SampleLeft, bus.SampleRight};
      w_pend_empty_n = 1'b0;
    end
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_div        <= '0;
      r_slot       <= '0;
      r_shift      <= '0;
      r_pend       <= '0;
      r_pend_empty <= 1'b1;
      r_bclk       <= 1'b0;
      r_lrclk      <= 1'b0;
      r_sdata      <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_div        <= w_div_n;
      r_slot       <= w_slot_n;
      r_shift      <= w_shift_n;
      r_pend       <= w_pend_n;
      r_pend_empty <= w_pend_empty_n;
      r_bclk       <= w_bclk_n;
      r_lrclk      <= w_lrclk_n;
      r_sdata      <= w_sdata_n;
      r_underrun   <= w_underrun_n;
    end
  end

  assign bus.SampleReady = r_pend_empty;
  assign bus.BCLK        = r_bclk;
  assign bus.LRCLK       = r_lrclk;
  assign bus.SDATA       = r_sdata;
  assign bus.Underrun    = r_underrun;
endmodule

`default_nettype wire

// File: tb/tb_audio_i2s_transmitter.sv
// +--------------------------------------------------------------------------+
// | tb_audio_i2s_transmitter : bench for audio_i2s_transmitter               |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_audio_i2s_transmitter;
  localparam int W     = 16;
  localparam int DIV   = 10;
  localparam int SLOTS = 2 * W;
  localparam int FRAME = SLOTS * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_i2s_transmitter_if #(.DATA_WIDTH(W)) bus ();

  audio_i2s_transmitter #(.DATA_WIDTH(W), .BCLK_DIV(DIV)) dut (
    .MasterCLK (clk),
    .Reset     (rst),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Reference model: everything follows from cycles elapsed since the stream started.
  logic             m_run = 1'b0;
  int               m_c = 0;
  logic             m_full = 1'b0;
  logic [SLOTS-1:0] m_pend = '0;
  logic [SLOTS-1:0] m_frame = '0;
  logic             m_prev = 1'b0;
  logic             m_take;
  int               m_div, m_slot;
  logic e_rdy = 1'b1, e_bclk = 1'b0, e_lr = 1'b0, e_sd = 1'b0, e_und = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_c = 0; m_full = 1'b0; m_frame = '0; m_prev = 1'b0;
      e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0; e_und = 1'b0;
    end else begin
      m_take = bus.SampleValid && !m_full;
      e_und  = 1'b0;
      if (!bus.Enable) begin
        m_run = 1'b0; m_c = 0; m_frame = '0;
        e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0;
      end else begin
        if (m_run) m_c = m_c + 1;
        else begin m_run = 1'b1; m_c = 0; end
        if (m_c % FRAME == 0) begin
          m_prev = m_frame[0];
          if (m_full) begin m_frame = m_pend; m_full = 1'b0; end
          else begin m_frame = '0; e_und = 1'b1; end
        end
        m_div  = m_c % DIV;
        m_slot = (m_c / DIV) % SLOTS;
        e_bclk = (m_div >= DIV / 2);
        e_lr   = (m_slot >= W - 1) && (m_slot <= 2 * W - 2);
        e_sd   = (m_slot == 0) ? m_prev : m_frame[SLOTS - m_slot];
      end
      if (m_take) begin m_pend = {bus.SampleLeft, bus.SampleRight}; m_full = 1'b1; end
    end
    e_rdy = !m_full;
  end

  logic [4:0] c_act, c_exp;
  always @(negedge clk) begin
    if (chk_en) begin
      c_act = {bus.SampleReady, bus.BCLK, bus.LRCLK, bus.SDATA, bus.Underrun};
      c_exp = {e_rdy, e_bclk, e_lr, e_sd, e_und};
      n_cmp++;
      if (c_act !== c_exp) begin
        n_err++;
        $display("FAIL model t=%0t rdy/bclk/lr/sd/und got %b expected %b", $time, c_act, c_exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reset, then enable; the first edge is a frame start that optionally also accepts a pair.
  task automatic start_run(input logic [W-1:0] l, input logic [W-1:0] r, input logic push);
    rst = 1'b1; bus.Enable = 1'b0; bus.SampleValid = 1'b0;
    tick(2);
    rst = 1'b0; bus.Enable = 1'b1; bus.SampleValid = push;
    bus.SampleLeft = l; bus.SampleRight = r;
    tick(1);
    bus.SampleValid = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0]     left;
    logic [W-1:0]     right;
    logic [SLOTS-1:0] exp_stream;
    logic [SLOTS-1:0] exp_lr;
  } vec_t;

  vec_t       vecs[4];
  logic [31:0] stream, lrmask;
  int         xfers, unders, highs;
  logic       xfer_next;
  logic [15:0] cnt;

  initial begin
    bus.Enable = 1'b0; bus.SampleValid = 1'b0;
    bus.SampleLeft = '0; bus.SampleRight = '0;
    vecs[0] = '{16'hA5C3, 16'h0F0F, 32'hA5C30F0F, 32'h7FFF8000};
    vecs[1] = '{16'h8000, 16'h0001, 32'h80000001, 32'h7FFF8000};
    vecs[2] = '{16'hFFFF, 16'h0000, 32'hFFFF0000, 32'h7FFF8000};
    vecs[3] = '{16'h1234, 16'hFEDC, 32'h1234FEDC, 32'h7FFF8000};
    tick(1);
    chk_en = 1'b1;

    // Pair pushed on the first frame start: that frame is zero, the next carries it.
    for (int i = 0; i < 4; i++) begin
      start_run(vecs[i].left, vecs[i].right, 1'b1);
      check("first_frame_underrun", {31'd0, bus.Underrun}, 32'd1);
      stream = '0; lrmask = '0;
      tick(FRAME + 5);
      for (int k = 0; k <= SLOTS; k++) begin
        if (k >= 1 && k < SLOTS) stream[SLOTS - k] = bus.SDATA;
        if (k < SLOTS)            lrmask[k] = bus.LRCLK;
        if (k == SLOTS)           stream[0] = bus.SDATA;
        if (k < SLOTS) tick(DIV);
      end
      check("frame_stream", stream, vecs[i].exp_stream);
      check("lrclk_slots", lrmask, vecs[i].exp_lr);
    end

    // Valid held high with incrementing pairs: one transfer per frame after the fill.
    rst = 1'b1; bus.Enable = 1'b0; bus.SampleValid = 1'b0;
    tick(2);
    rst = 1'b0; bus.Enable = 1'b1; bus.SampleValid = 1'b1;
    cnt = 16'h0100; xfers = 0; unders = 0;
    bus.SampleLeft = cnt; bus.SampleRight = ~cnt;
    for (int i = 0; i < 5 * FRAME; i++) begin
      xfer_next = bus.SampleReady;
      tick(1);
      if (xfer_next) begin
        xfers++; cnt = cnt + 16'd1;
        bus.SampleLeft = cnt; bus.SampleRight = ~cnt;
      end
      if (bus.Underrun) unders++;
    end
    bus.SampleValid = 1'b0;
    check("stream_transfers", xfers, 32'd5);
    check("stream_underruns", unders, 32'd1);

    // Push in the exact cycle of an empty-buffer frame start.
    start_run(16'h0, 16'h0, 1'b0);
    tick(FRAME - 1);
    bus.SampleValid = 1'b1; bus.SampleLeft = 16'h8001; bus.SampleRight = 16'h7FFE;
    tick(1);
    bus.SampleValid = 1'b0;
    check("coincident_underrun_ready", {30'd0, bus.Underrun, bus.SampleReady}, 32'h2);
    tick(FRAME + 15);
    check("coincident_next_frame_msb", {31'd0, bus.SDATA}, 32'd1);

    // Enable dropped at slot 20, then restarted with a pair pending.
    start_run(16'hC3A5, 16'h5A3C, 1'b1);
    tick(FRAME + 9);
    bus.SampleValid = 1'b1; bus.SampleLeft = 16'hF00D; bus.SampleRight = 16'hBEEF;
    tick(1);
    bus.SampleValid = 1'b0;
    tick(194);
    bus.Enable = 1'b0;
    tick(1);
    check("disable_pins_low", {29'd0, bus.BCLK, bus.LRCLK, bus.SDATA}, 32'd0);
    tick(3);
    bus.Enable = 1'b1;
    tick(1);
    check("reenable_load", {30'd0, bus.Underrun, bus.SampleReady}, 32'h1);
    tick(4);
    check("reenable_bclk_low", {31'd0, bus.BCLK}, 32'd0);
    tick(1);
    check("reenable_bclk_rise", {31'd0, bus.BCLK}, 32'd1);
    tick(FRAME + 10);

    // Reset mid-frame with a full buffer: that pair must never be sent.
    start_run(16'h0000, 16'h0000, 1'b1);
    tick(FRAME - 1);
    bus.SampleValid = 1'b1; bus.SampleLeft = 16'hFFFF; bus.SampleRight = 16'hFFFF;
    tick(2);
    bus.SampleValid = 1'b0;
    tick(100);
    rst = 1'b1;
    tick(1);
    check("reset_outputs", {27'd0, bus.BCLK, bus.LRCLK, bus.SDATA, bus.Underrun, bus.SampleReady}, 32'd1);
    rst = 1'b0;
    tick(1);
    check("reset_then_underrun", {31'd0, bus.Underrun}, 32'd1);
    highs = 0;
    for (int i = 0; i < 2 * FRAME + 20; i++) begin
      tick(1);
      if (bus.SDATA) highs++;
    end
    check("reset_pair_discarded", highs, 32'd0);

    // Random traffic, enable toggles and occasional resets against the model.
    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom_range(0, 1999) == 0);
      if (!bus.Enable) bus.Enable = ($urandom_range(0, 9) == 0);
      else if ($urandom_range(0, 799) == 0) bus.Enable = 1'b0;
      bus.SampleValid = ($urandom_range(0, 3) == 0);
      bus.SampleLeft  = 16'($urandom);
      bus.SampleRight = 16'($urandom);
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
